// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller.
// Holds the FSM state encoding, the power-up init ROM and the long-command classifier.
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_INIT_SETUP,
    ST_INIT_EN,
    ST_INIT_HOLD,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  // 8-bit bus, 2 lines; display on; clear; entry mode increment.
  localparam logic [7:0] LCD_INIT_ROM [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear/home (0x01..0x03 as instructions) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter shared by every timed state of the LCD controller.
// Load wins over counting; o_done flags the last cycle of a timed interval (count == 1).
module lcd_delay_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_load)
      cnt_reg <= i_value;
    else if (cnt_reg != '0)
      cnt_reg <= cnt_reg - 1'b1;
  end

  assign o_done = (cnt_reg == W'(1));

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 controller: power-up init sequence plus valid/ready command path,
// generating RS/DATA setup, EN pulse, hold and execution wait with one shared counter.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP_CYC = 2_000_000,
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_CMD_CYC   = 2_000,
  parameter int T_CLR_CYC   = 82_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cmd_vld,
  output logic       o_cmd_rdy,
  input  logic       i_cmd_rs,
  input  logic [7:0] i_cmd_data,
  input  logic       i_lcd_on,
  output logic       o_busy,
  output logic       o_init_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on
);

  localparam int T_MAX = max_of(max_of(max_of(T_PWRUP_CYC, T_SETUP_CYC), max_of(T_EN_CYC, T_HOLD_CYC)),
                                max_of(T_CMD_CYC, T_CLR_CYC));
  localparam int CW = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] C_PWRUP = CW'(T_PWRUP_CYC);
  localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP_CYC);
  localparam logic [CW-1:0] C_EN    = CW'(T_EN_CYC);
  localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD_CYC);
  localparam logic [CW-1:0] C_CMD   = CW'(T_CMD_CYC);
  localparam logic [CW-1:0] C_CLR   = CW'(T_CLR_CYC);

  generate
    if (T_PWRUP_CYC < 1 || T_SETUP_CYC < 1 || T_EN_CYC < 1 ||
        T_HOLD_CYC < 1 || T_CMD_CYC < 1 || T_CLR_CYC < 1) begin : g_bad_timing
      $error("lcd_hd44780_ctrl: every T_* timing parameter must be >= 1");
    end
  endgenerate

  lcd_state_e    state_reg;
  logic [1:0]    step_reg;
  logic [7:0]    data_reg;
  logic          rs_reg;
  logic          en_reg;
  logic          rdy_reg;
  logic          init_done_reg;
  logic          lcd_on_reg;

  logic          cnt_load;
  logic [CW-1:0] cnt_value;
  logic          cnt_done;
  logic          accept;
  logic [CW-1:0] wait_value;

  assign accept = i_cmd_vld && rdy_reg;
  // Pins already hold the step/command being executed, so init and normal paths share this.
  assign wait_value = is_long_cmd(rs_reg, data_reg) ? C_CLR : C_CMD;

  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    if (!i_reset) begin
      cnt_load  = 1'b1;
      cnt_value = C_PWRUP;
    end else begin
      case (state_reg)
        ST_PWRUP: begin
          cnt_load  = cnt_done;
          cnt_value = C_SETUP;
        end
        ST_INIT_WAIT: begin
          cnt_load  = cnt_done && (step_reg != 2'd3);
          cnt_value = C_SETUP;
        end
        ST_INIT_SETUP, ST_SETUP: begin
          cnt_load  = cnt_done;
          cnt_value = C_EN;
        end
        ST_INIT_EN, ST_EN_HI: begin
          cnt_load  = cnt_done;
          cnt_value = C_HOLD;
        end
        ST_INIT_HOLD, ST_HOLD: begin
          cnt_load  = cnt_done;
          cnt_value = wait_value;
        end
        ST_IDLE: begin
          cnt_load  = accept;
          cnt_value = C_SETUP;
        end
        default: ;
      endcase
    end
  end

  lcd_delay_cnt #(.W(CW)) u_delay_cnt (
    .i_clk   (i_clk),
    .i_load  (cnt_load),
    .i_value (cnt_value),
    .o_done  (cnt_done)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_reg     <= ST_PWRUP;
      step_reg      <= 2'd0;
      data_reg      <= 8'h00;
      rs_reg        <= 1'b0;
      en_reg        <= 1'b0;
      rdy_reg       <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_PWRUP: if (cnt_done) begin
          state_reg <= ST_INIT_SETUP;
          step_reg  <= 2'd0;
          data_reg  <= LCD_INIT_ROM[0];
          rs_reg    <= 1'b0;
        end
        ST_INIT_SETUP: if (cnt_done) begin
          state_reg <= ST_INIT_EN;
          en_reg    <= 1'b1;
        end
        ST_INIT_EN: if (cnt_done) begin
          state_reg <= ST_INIT_HOLD;
          en_reg    <= 1'b0;
        end
        ST_INIT_HOLD: if (cnt_done) state_reg <= ST_INIT_WAIT;
        ST_INIT_WAIT: if (cnt_done) begin
          if (step_reg == 2'd3) begin
            state_reg     <= ST_IDLE;
            init_done_reg <= 1'b1;
            rdy_reg       <= 1'b1;
          end else begin
            state_reg <= ST_INIT_SETUP;
            step_reg  <= step_reg + 2'd1;
            data_reg  <= LCD_INIT_ROM[step_reg + 2'd1];
          end
        end
        ST_IDLE: if (accept) begin
          state_reg <= ST_SETUP;
          data_reg  <= i_cmd_data;
          rs_reg    <= i_cmd_rs;
          rdy_reg   <= 1'b0;
        end
        ST_SETUP: if (cnt_done) begin
          state_reg <= ST_EN_HI;
          en_reg    <= 1'b1;
        end
        ST_EN_HI: if (cnt_done) begin
          state_reg <= ST_HOLD;
          en_reg    <= 1'b0;
        end
        ST_HOLD: if (cnt_done) state_reg <= ST_WAIT;
        ST_WAIT: if (cnt_done) begin
          state_reg <= ST_IDLE;
          rdy_reg   <= 1'b1;
        end
        default: begin
          state_reg <= ST_PWRUP;
          en_reg    <= 1'b0;
          rdy_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Power enable is a plain pipelined copy, independent of the FSM.
  always_ff @(posedge i_clk) begin
    if (!i_reset)
      lcd_on_reg <= 1'b0;
    else
      lcd_on_reg <= i_lcd_on;
  end

  assign o_cmd_rdy   = rdy_reg;
  assign o_busy      = !rdy_reg;
  assign o_init_done = init_done_reg;
  assign o_lcd_data  = data_reg;
  assign o_lcd_rs    = rs_reg;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = en_reg;
  assign o_lcd_on    = lcd_on_reg;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl with shortened timing; an EN-edge monitor
// pops expected {rs,data} from a scoreboard queue and checks pulse width.
`timescale 1ns/1ps
module tb_lcd_hd44780_ctrl;

  localparam int PW  = 20;
  localparam int SU  = 2;
  localparam int ENC = 4;
  localparam int HO  = 2;
  localparam int CMD = 10;
  localparam int CLR = 30;
  localparam int INIT_CYC  = PW + 4 * (SU + ENC + HO) + 3 * CMD + CLR;
  localparam int CMD_BUSY  = SU + ENC + HO + CMD;
  localparam int CLR_BUSY  = SU + ENC + HO + CLR;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       lcd_on_in;
  logic       busy;
  logic       init_done;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;

  int   checks = 0;
  int   errors = 0;
  int   en_pulses = 0;
  int   en_len = 0;
  bit   cut_ok = 1'b0;
  logic prev_en = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_item;

  lcd_hd44780_ctrl #(
    .T_PWRUP_CYC(PW), .T_SETUP_CYC(SU), .T_EN_CYC(ENC),
    .T_HOLD_CYC(HO), .T_CMD_CYC(CMD), .T_CLR_CYC(CLR)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_cmd_vld   (cmd_vld),
    .o_cmd_rdy   (cmd_rdy),
    .i_cmd_rs    (cmd_rs),
    .i_cmd_data  (cmd_data),
    .i_lcd_on    (lcd_on_in),
    .o_busy      (busy),
    .o_init_done (init_done),
    .o_lcd_data  (lcd_data),
    .o_lcd_rs    (lcd_rs),
    .o_lcd_rw    (lcd_rw),
    .o_lcd_en    (lcd_en),
    .o_lcd_on    (lcd_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // EN monitor: each rising edge consumes one scoreboard entry; each falling edge checks width.
  always @(negedge clk) begin
    if (lcd_en && !prev_en) begin
      en_pulses++;
      en_len = 1;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL en_unexpected: observed pulse rs=%0d data=%02h, expected none", lcd_rs, lcd_data);
      end
      if (exp_q.size() != 0) begin
        exp_item = exp_q.pop_front();
        check("en_pins", {23'd0, lcd_rs, lcd_data}, {23'd0, exp_item});
      end
    end else if (lcd_en) begin
      en_len++;
    end else if (prev_en && !cut_ok) begin
      check("en_width", en_len, ENC);
    end
    prev_en = lcd_en;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Counts samples until rdy rises; also reports first/last sample with EN high.
  task automatic wait_rdy(output int n, output int first_en, output int last_en);
    n = 0; first_en = -1; last_en = -1;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (lcd_en) begin
        if (first_en < 0) first_en = n;
        last_en = n;
      end
      if (cmd_rdy) break;
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    cmd_vld  = 1'b1;
    cmd_rs   = rs;
    cmd_data = d;
    exp_q.push_back({rs, d});
    tick();
    cmd_vld = 1'b0;
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  initial begin
    int n, n2, fe, le;
    reset = 1'b0; cmd_vld = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00; lcd_on_in = 1'b1;
    repeat (3) tick();
    check("rst_en", lcd_en, 0);
    check("rst_data", lcd_data, 8'h00);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_on", lcd_on, 0);
    check("rst_rdy", cmd_rdy, 0);
    check("rst_busy", busy, 1);
    check("rst_init_done", init_done, 0);

    // 1: power-up and init sequence
    push_init();
    reset = 1'b1;
    wait_rdy(n, fe, le);
    check("init_cycles", n, INIT_CYC);
    check("init_first_en", fe, PW + SU);
    check("init_done", init_done, 1);
    check("init_busy", busy, 0);
    check("init_pulses", en_pulses, 4);
    check("init_queue_empty", exp_q.size(), 0);
    check("on_follow_hi", lcd_on, 1);
    lcd_on_in = 1'b0;
    tick();
    check("on_follow_lo", lcd_on, 0);
    lcd_on_in = 1'b1;

    // 2: character write
    send(1'b1, 8'h41);
    check("c41_data", lcd_data, 8'h41);
    check("c41_rs", lcd_rs, 1);
    check("c41_rdy", cmd_rdy, 0);
    check("c41_busy", busy, 1);
    wait_rdy(n, fe, le);
    check("c41_rdy_cycles", n, CMD_BUSY);
    check("c41_en_first", fe, SU);
    check("c41_en_last", le, SU + ENC - 1);
    check("c41_pulses", en_pulses, 5);

    // 3: clear display uses the long wait
    send(1'b0, 8'h01);
    wait_rdy(n, fe, le);
    check("clr_busy_cycles", n, CLR_BUSY);
    check("clr_en_first", fe, SU);
    check("clr_pulses", en_pulses, 6);

    // 4: vld held high across two transactions
    cmd_vld = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h48;
    exp_q.push_back({1'b1, 8'h48});
    exp_q.push_back({1'b1, 8'h49});
    tick();
    check("b48_data", lcd_data, 8'h48);
    cmd_data = 8'h49;
    wait_rdy(n, fe, le);
    check("b48_busy_cycles", n, CMD_BUSY);
    check("b48_pins_held", lcd_data, 8'h48);
    tick();
    check("b49_rdy", cmd_rdy, 0);
    check("b49_data", lcd_data, 8'h49);
    cmd_vld = 1'b0;
    wait_rdy(n, fe, le);
    check("b49_busy_cycles", n, CMD_BUSY);
    check("b_pulses", en_pulses, 8);

    // 5: vld during WAIT is ignored
    send(1'b1, 8'h5A);
    repeat (10) tick();
    cmd_vld = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h01;
    repeat (5) tick();
    check("wait_ign_data", lcd_data, 8'h5A);
    check("wait_ign_rs", lcd_rs, 1);
    check("wait_ign_rdy", cmd_rdy, 0);
    cmd_vld = 1'b0;
    wait_rdy(n, fe, le);
    check("wait_ign_remaining", n, CMD_BUSY - 15);
    check("wait_ign_pulses", en_pulses, 9);

    // 6: reset while EN is high, then full init rerun with vld asserted
    send(1'b0, 8'h0C);
    repeat (2) tick();
    check("mid_en_high", lcd_en, 1);
    cut_ok = 1'b1;
    reset = 1'b0;
    tick();
    check("mid_rst_en", lcd_en, 0);
    check("mid_rst_data", lcd_data, 8'h00);
    check("mid_rst_init_done", init_done, 0);
    check("mid_rst_rdy", cmd_rdy, 0);
    push_init();
    tick();
    cmd_vld = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h55;
    reset = 1'b1;
    repeat (10) tick();
    cut_ok = 1'b0;
    check("pwrup_ign_data", lcd_data, 8'h00);
    check("pwrup_ign_en", lcd_en, 0);
    repeat (80) tick();
    cmd_vld = 1'b0;
    wait_rdy(n2, fe, le);
    check("rerun_cycles", 90 + n2, INIT_CYC);
    check("rerun_init_done", init_done, 1);
    check("rerun_last_data", lcd_data, 8'h06);
    check("rerun_pulses", en_pulses, 14);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100 us");
    $fatal(1, "watchdog expired");
  end

endmodule
